// File: rtl/std_gray_pointer.sv
// std_gray_pointer: one side of a dual-clock FIFO pointer pair (full/empty).
// Optional fill level output enabled by defining STD_GRAY_POINTER_LEVEL_EN.
module std_gray_pointer #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit IS_WRITE    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic [WIDTH:0]   i_remote_gray,
  output logic [WIDTH:0]   o_ptr_gray,
  output logic [WIDTH-1:0] o_addr,
  output logic             o_status,
  output logic [WIDTH:0]   o_level
);

  localparam logic [WIDTH:0] FULL_MASK =
    {2'b11, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] bin_q;
  logic [WIDTH:0] gray_q;
  logic           status_q;
  logic [WIDTH:0] sync_q [SYNC_STAGES];

  logic           adv;
  logic [WIDTH:0] bin_next;
  logic [WIDTH:0] gray_next;
  logic [WIDTH:0] rg_sync;
  logic           status_next;

  assign adv       = i_inc & ~status_q;
  assign bin_next  = bin_q + {{WIDTH{1'b0}}, adv};
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign rg_sync   = sync_q[SYNC_STAGES-1];

  // Write side is full when the pointers differ only in the top two Gray bits
  always_comb begin
    status_next = 1'b0;
    if (IS_WRITE)
      status_next = (gray_next == (rg_sync ^ FULL_MASK));
    else
      status_next = (gray_next == rg_sync);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q    <= '0;
      gray_q   <= '0;
      status_q <= !IS_WRITE;
    end else begin
      bin_q    <= bin_next;
      gray_q   <= gray_next;
      status_q <= status_next;
    end
  end

  assign o_ptr_gray = gray_q;
  assign o_addr     = bin_q[WIDTH-1:0];
  assign o_status   = status_q;

`ifdef STD_GRAY_POINTER_LEVEL_EN
  logic [WIDTH:0] rb_sync;
  logic [WIDTH:0] level_next;
  logic [WIDTH:0] level_q;

  // Gray to binary: bit k is the XOR of all bits at or above k
  always_comb begin
    rb_sync = '0;
    for (int k = 0; k <= WIDTH; k++)
      rb_sync[k] = ^(rg_sync >> k);
  end

  always_comb begin
    level_next = '0;
    if (IS_WRITE)
      level_next = bin_next - rb_sync;
    else
      level_next = rb_sync - bin_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      level_q <= '0;
    else
      level_q <= level_next;
  end

  assign o_level = level_q;
`else
  assign o_level = '0;
`endif

endmodule

// File: doc/std_gray_pointer.md
# std_gray_pointer

Single-clock-domain pointer stage for a dual-clock FIFO, one instance per side. It keeps the local binary pointer and publishes it as a registered, glitch-free Gray code for the other domain. It resynchronizes the remote side's Gray pointer through a flop chain and converts it back to binary. From the two pointers it derives a registered full (write side) or empty (read side) flag and a fill level.

## Interface
- WIDTH, 4, address bits; FIFO depth is 2**WIDTH; pointers are WIDTH+1 bits.
- SYNC_STAGES, 2, synchronizer flops on i_remote_gray; legal range 2..4.
- IS_WRITE, 1, 1 selects write-side behaviour (full flag); 0 selects read-side behaviour (empty flag).
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous assert, active-low; release is synchronous to i_clk externally.
- i_inc  input  1  request to advance the local pointer by one.
- i_remote_gray  input  WIDTH+1  Gray pointer from the other clock domain; asynchronous to i_clk.
- o_ptr_gray  output  WIDTH+1  registered local pointer in Gray code, crossing to the other domain.
- o_addr  output  WIDTH  binary RAM address (low WIDTH bits of the local binary pointer).
- o_status  output  1  full when IS_WRITE=1, empty when IS_WRITE=0.
- o_level  output  WIDTH+1  number of occupied entries as seen from this side, range 0..2**WIDTH.

## Operation
- Local state:
  - bin_q, WIDTH+1 bits, binary pointer.
  - gray_q = registered (bin_next >> 1) ^ bin_next.
- Advance rule:
  - adv = i_inc & ~o_status.
  - bin_next = bin_q + adv, modulo 2**(WIDTH+1), so the pointer wraps naturally.
  - i_inc while o_status=1 is ignored; there is no error flag.
- Remote path:
  - i_remote_gray → SYNC_STAGES flops → rg_sync.
  - rg_sync is converted to binary by XOR-folding: bit k = XOR of rg_sync[WIDTH:k].
  - The result is rb_sync, which is purely combinational from rg_sync.
- Status, registered, evaluated using gray_next/bin_next:
  - Write side: full_next = (gray_next == {~rg_sync[WIDTH:WIDTH-1], rg_sync[WIDTH-2:0]}).
  - Read side: empty_next = (gray_next == rg_sync).
- Level, registered:
  - Write side: bin_next − rb_sync.
  - Read side: rb_sync − bin_next.
  - Both are computed modulo 2**(WIDTH+1).
- The status flag is pessimistic by construction: it deasserts late and never asserts late.
- Simultaneous i_inc and a remote update in the same cycle: both take effect; status reflects the new local pointer and the already-synchronized remote value.
- The remote pointer is trusted to be Gray-coded. Multi-bit changes on i_remote_gray are undefined.

## Timing
- Reset values (asynchronous, while i_rst_n=0):
  - bin_q=0, o_ptr_gray=0, o_addr=0, all sync flops 0, o_level=0.
  - o_status=0 when IS_WRITE=1; o_status=1 when IS_WRITE=0.
- i_inc sampled at edge N: o_ptr_gray, o_addr, o_status and o_level update at edge N, visible cycle N+1. There are no extra cycles of latency.
- i_remote_gray change stable before edge N:
  - rg_sync updates after SYNC_STAGES edges.
  - o_status/o_level reflect it one edge later, i.e. SYNC_STAGES+1 edges total.
- o_ptr_gray comes directly from a flop and changes at most one bit per edge.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. In-flight synchronizer contents are discarded.

## Configuration
- STD_GRAY_POINTER_LEVEL_EN:
  - Defined: o_level is computed and registered as specified above.
  - Undefined: the subtractor and the level register are removed, and o_level is tied to 0.
  - Pointer and status behaviour are identical in both cases.

## Test plan
All scenarios use WIDTH=2 and SYNC_STAGES=2.
- Reset:
  - Stimulus: assert i_rst_n=0 mid-clock with i_inc=1.
  - Required: all outputs go to reset values without a clock edge. o_status=0 with IS_WRITE=1, 1 with IS_WRITE=0.
- Write fill:
  - Stimulus: IS_WRITE=1, i_remote_gray=000, i_inc=1 for 5 cycles.
  - Required: o_ptr_gray steps 001, 011, 010, 110.
  - Required: o_status=1 after the 4th increment and o_level=4.
  - Required: the 5th increment is ignored; o_ptr_gray stays 110 and o_addr stays 0.
- Write drain:
  - Stimulus: from full, set i_remote_gray=001.
  - Required: o_status falls, and o_level goes 4→3, exactly 3 edges later.
- Read side:
  - Stimulus: IS_WRITE=0, set i_remote_gray=011 (binary 2).
  - Required: o_status falls and o_level=2 three edges later.
  - Stimulus: then 2 increments.
  - Required: o_status=1 at the edge registering the 2nd increment, and o_level=0.
- Wrap-around:
  - Stimulus: IS_WRITE=0, remote held 4 ahead, 8 increments.
  - Required: o_addr sequence 0,1,2,3,0,1,2,3.
  - Required: o_ptr_gray returns to 000; every transition is a single-bit change.
- Macro-off build:
  - Stimulus: repeat the write-fill scenario.
  - Required: identical o_ptr_gray/o_status behaviour, with o_level constantly 0.
